// File: rtl/pe_rate_meter_pkg.sv
// rtl/pe_rate_meter_pkg.sv - shared constants and state encoding for the pulse rate meter
package pe_rate_meter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   localparam int DEF_GATE_CYCLES = 16;
   localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/pe_gate_timer.sv
// rtl/pe_gate_timer.sv - gate window timer; last marks the final cycle of a window
module pe_gate_timer
   import pe_rate_meter_pkg::*;
#(
   parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic last
);

   localparam int TW = $clog2(GATE_CYCLES);
   localparam logic [TW-1:0] LAST_VAL = TW'(GATE_CYCLES - 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   assign last = (timer_q == LAST_VAL);

   // Wraps to zero after the final cycle so back-to-back windows need no dead cycle.
   always_comb begin
      timer_d = timer_q;
      if (clr) begin
         timer_d = '0;
      end else if (run) begin
         if (last) begin
            timer_d = '0;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/pe_rate_meter.sv
// rtl/pe_rate_meter.sv - counts pe events over fixed gate windows and reports each completed window
module pe_rate_meter
   import pe_rate_meter_pkg::*;
#(
   parameter int GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pe,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             valid,
   output logic             busy
);

   localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

   logic             tmr_run;
   logic             tmr_clr;
   logic             tmr_last;
   logic [CNT_W-1:0] acc_inc;
   logic             sat_hit;

   pe_gate_timer #(
      .GATE_CYCLES(GATE_CYCLES)
   ) u_gate_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (tmr_run),
      .clr  (tmr_clr),
      .last (tmr_last)
   );

   assign tmr_run = (state_q == GATE);
   assign tmr_clr = (state_q == IDLE) || (!en && !tmr_last);

   always_comb begin
      acc_inc = acc_q;
      sat_hit = 1'b0;
      if (pe) begin
         if (acc_q == ACC_MAX) begin
            sat_hit = 1'b1;
         end else begin
            acc_inc = acc_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      valid_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = GATE;
               acc_d     = '0;
               ovf_acc_d = 1'b0;
            end
         end
         GATE: begin
            // The final cycle completes the window even if en has just dropped.
            if (tmr_last) begin
               count_d   = acc_inc;
               ovf_d     = ovf_acc_q | sat_hit;
               valid_d   = 1'b1;
               acc_d     = '0;
               ovf_acc_d = 1'b0;
               state_d   = en ? GATE : IDLE;
            end else if (!en) begin
               state_d   = IDLE;
               acc_d     = '0;
               ovf_acc_d = 1'b0;
            end else begin
               acc_d     = acc_inc;
               ovf_acc_d = ovf_acc_q | sat_hit;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         ovf_acc_q <= 1'b0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         ovf_acc_q <= ovf_acc_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;
   assign valid = valid_q;
   assign busy  = (state_q == GATE);

endmodule

// File: tb/tb_pe_rate_meter.sv
// tb/tb_pe_rate_meter.sv - directed self-checking bench for pe_rate_meter (GATE_CYCLES=16, CNT_W=4)
module tb_pe_rate_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       pe;
   logic       en;
   logic [3:0] count;
   logic       ovf;
   logic       valid;
   logic       busy;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;
   logic prev_valid = 1'b0;
   int first_valid_edge;
   int vcyc_a;
   int vcyc_b;

   pe_rate_meter #(
      .GATE_CYCLES(16),
      .CNT_W      (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .pe    (pe),
      .en    (en),
      .count (count),
      .ovf   (ovf),
      .valid (valid),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge with the given inputs; outputs sampled 1 time unit after it.
   task automatic step(input logic r, input logic p, input logic e);
      rst = r;
      pe  = p;
      en  = e;
      @(posedge clk);
      #1;
      cyc++;
      if (valid) chk("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
      prev_valid = valid;
   endtask

   task automatic chk_all(input string tag, input int c, input int o, input int v, input int b);
      chk({tag, "_count"}, {28'd0, count}, c);
      chk({tag, "_ovf"},   {31'd0, ovf},   o);
      chk({tag, "_valid"}, {31'd0, valid}, v);
      chk({tag, "_busy"},  {31'd0, busy},  b);
   endtask

   initial begin
      rst = 1'b1;
      pe  = 1'b0;
      en  = 1'b0;

      // Reset held two cycles with pe toggling
      step(1'b1, 1'b1, 1'b0);
      chk_all("reset1", 0, 0, 0, 0);
      step(1'b1, 1'b0, 1'b1);
      chk_all("reset2", 0, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0);
      chk_all("idle", 0, 0, 0, 0);

      // Window 1: pe in the IDLE entry cycle is not counted; 5 pulses in the window
      first_valid_edge = 0;
      for (int k = 0; k <= 30; k++) begin
         step(1'b0, (k == 0) || (k inside {1, 3, 5, 7, 9}), 1'b1);
         if (k == 0) chk("enter_busy", {31'd0, busy}, 32'd1);
         if (valid && first_valid_edge == 0) begin
            first_valid_edge = k + 1;
            break;
         end
      end
      chk("w1_valid_edge", first_valid_edge, 17);
      chk_all("w1", 5, 0, 1, 1);

      // Window 2: saturation
      for (int k = 1; k <= 16; k++) begin
         step(1'b0, 1'b1, 1'b1);
         if (k == 1) chk("w2_valid_drop", {31'd0, valid}, 32'd0);
         if (k == 8) chk("w2_count_held", {28'd0, count}, 32'd5);
      end
      chk_all("w2_sat", 15, 1, 1, 1);

      // Window 3: 3 pulses, the last on the final cycle
      for (int k = 1; k <= 16; k++) step(1'b0, k inside {2, 4, 16}, 1'b1);
      chk_all("w3", 3, 0, 1, 1);
      vcyc_a = cyc;

      // Window 4: pulse on the first cycle after the boundary, plus one more
      for (int k = 1; k <= 16; k++) step(1'b0, k inside {1, 10}, 1'b1);
      chk_all("w4", 2, 0, 1, 1);
      vcyc_b = cyc;
      chk("valid_spacing", vcyc_b - vcyc_a, 16);

      // Abort: en dropped at timer=7
      for (int k = 1; k <= 7; k++) step(1'b0, k inside {2, 5}, 1'b1);
      chk("abort_pre_busy", {31'd0, busy}, 32'd1);
      step(1'b0, 1'b1, 1'b0);
      chk_all("abort", 2, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
      chk_all("abort_idle", 2, 0, 0, 0);

      // Reset at timer=10 mid-window
      step(1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) step(1'b0, k[0], 1'b1);
      chk("rst_pre_busy", {31'd0, busy}, 32'd1);
      step(1'b1, 1'b1, 1'b1);
      chk_all("mid_reset", 0, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0);
      chk_all("post_reset", 0, 0, 0, 0);

      // en dropped on the final cycle still latches the window
      step(1'b0, 1'b1, 1'b1);
      for (int k = 1; k <= 15; k++) step(1'b0, k inside {1, 2, 3, 4}, 1'b1);
      chk("final_pre_valid", {31'd0, valid}, 32'd0);
      step(1'b0, 1'b1, 1'b0);
      chk_all("final_en_drop", 5, 0, 1, 0);
      step(1'b0, 1'b0, 1'b0);
      chk_all("final_idle", 5, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
